sync_fifo_flagged: RTL and testbench
====================================

# sync_fifo_flagged

Single-clock, parametrised FIFO for buffering 41-bit AHB-to-SPI transfer words inside one clock domain, e.g. command staging ahead of the clock-crossing FIFO or SPI-side response buffering. It adds the following on top of plain full/empty flags:

- an occupancy count,
- programmable almost-full and almost-empty thresholds,
- sticky overflow and underflow error flags,
- a synchronous flush.

Read data is registered and qualified by a one-cycle valid strobe.

## Interface
- DATA_WIDTH, 41, word width in bits
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
- AF_THRESH, 12, almost_full asserts when level >= AF_THRESH
- AE_THRESH, 2, almost_empty asserts when level <= AE_THRESH
- Legal parameter range: 0 <= AE_THRESH < AF_THRESH <= DEPTH; ADDR_WIDTH >= 1.

Ports:
- clk  in  1  the single clock; all state changes on its rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of contents and error flags
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write word
- rd_en  in  1  read request
- rd_data  out  DATA_WIDTH  registered read word
- rd_valid  out  1  one-cycle strobe; rd_data holds a freshly read word
- full  out  1  level == DEPTH
- empty  out  1  level == 0
- almost_full  out  1  level >= AF_THRESH
- almost_empty  out  1  level <= AE_THRESH
- level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

## Operation
- **Storage:** DEPTH x DATA_WIDTH array, not reset. Write and read pointers are ADDR_WIDTH bits wide and wrap modulo DEPTH.
- **Write acceptance:** a write is accepted iff wr_en && !full, using the value of full before the edge.
  - An accepted write stores wr_data at the write pointer and increments the pointer.
- **Read acceptance:** a read is accepted iff rd_en && !empty, using the value of empty before the edge.
  - On the edge, rd_data is loaded from the read pointer, the pointer increments, and rd_valid = 1 for that cycle.
- **level update on each edge:**
  - +1 on accepted write only.
  - -1 on accepted read only.
  - Unchanged when both or neither are accepted.
- **Flag derivation:** full, empty, almost_full and almost_empty are decoded from the registered level. They always reflect the state after the last edge.
- **Simultaneous read and write when full:** the read is accepted. The write is rejected, so overflow is set and level goes to DEPTH-1.
- **Simultaneous read and write when empty:** the write is accepted. The read is rejected, so underflow is set, rd_valid = 0 and level goes to 1.
- **Error flags:** overflow is set by a rejected wr_en and underflow by a rejected rd_en. Both hold until flush or rst.
- **flush (highest priority):**
  - Pointers, level, overflow, underflow and rd_valid go to 0.
  - wr_en and rd_en in the same cycle are ignored and set no error flag.
  - rd_data keeps its last value.
- **Data ordering:** strict first-in, first-out. There is no bypass, so a word written at edge N is readable no earlier than the request sampled at edge N+1.

## Timing
- **Reset values:**
  - rd_data = 0, rd_valid = 0, level = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - overflow = 0, underflow = 0.
- **Reset behaviour:** outputs go to their reset values immediately on rst assertion, with no clock needed. Operation resumes on the first clk edge after deassertion.
- **Write latency:** level and flags update at the edge that accepts the write.
- **Read latency:** rd_data and rd_valid are valid in the cycle after rd_en is sampled, i.e. one cycle.
- **Back-to-back reads:** rd_en held high yields consecutive words with rd_valid high every cycle until empty.
- **Throughput:** one write plus one read per cycle, sustained.
- **Reset mid-operation:** contents are discarded and the FIFO reports empty. Any in-flight rd_valid is cancelled.

## Test plan
All scenarios use default parameters: DEPTH 16, AF_THRESH 12, AE_THRESH 2.

1. **Reset:** assert rst asynchronously between edges -> all outputs take their reset values immediately. After release, empty = 1, almost_empty = 1, level = 0.
2. **Fill and drain:** write 0x000..0x00F on 16 consecutive cycles, then hold wr_en one more cycle ->
   - almost_empty clears when level reaches 3.
   - almost_full rises when level reaches 12.
   - full rises when level reaches 16.
   - The extra cycle sets overflow = 1 and level stays 16.
   - Then hold rd_en 16 cycles -> rd_data reads 0x000..0x00F in order with rd_valid high each cycle, and empty = 1 at the end.
3. **Read on empty:** rd_en for one cycle on an empty FIFO -> underflow = 1, rd_valid stays 0, level stays 0. A later flush clears underflow.
4. **Steady state with wrap:** preload 5 words, then drive wr_en and rd_en together for 40 cycles with incrementing data -> level constant at 5, pointers wrap at least twice, and the output sequence matches the input sequence exactly.
5. **Simultaneous at full:** with level 16, drive rd_en and wr_en together ->
   - rd_valid = 1 carrying the oldest word.
   - The write is dropped, overflow = 1.
   - level = 15, full = 0.
6. **Flush:** with level 9, overflow = 1, and wr_en high in the same cycle -> next cycle level = 0, empty = 1, overflow = 0, rd_valid = 0. rd_data is unchanged and the concurrent write is not stored.

Source files
------------

// File: rtl/sync_fifo_flagged.sv
// sync_fifo_flagged: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow flags and a
// synchronous flush. Read data is registered and qualified by rd_valid.
module sync_fifo_flagged #(
  parameter int DATA_WIDTH = 41,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_THRESH);

  // Storage is deliberately left without reset; pointers define what is valid.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;

  logic                  wr_accept_s;
  logic                  rd_accept_s;

  // Acceptance uses the registered flags, i.e. the state before the edge;
  // flush suppresses both ports.
  assign wr_accept_s = wr_en & ~full_q  & ~flush;
  assign rd_accept_s = rd_en & ~empty_q & ~flush;

  // Next-state computation for pointers, level, read port, error and status flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (flush) begin
      // rd_data intentionally keeps its last value across a flush.
      wr_ptr_d    = {ADDR_WIDTH{1'b0}};
      rd_ptr_d    = {ADDR_WIDTH{1'b0}};
      level_d     = {(ADDR_WIDTH+1){1'b0}};
      rd_valid_d  = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_accept_s) begin
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end

      if (rd_accept_s) begin
        rd_ptr_d   = rd_ptr_q + ADDR_WIDTH'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end else begin
        rd_ptr_d   = rd_ptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
      end

      case ({wr_accept_s, rd_accept_s})
        2'b10:   level_d = level_q + (ADDR_WIDTH+1)'(1);
        2'b01:   level_d = level_q - (ADDR_WIDTH+1)'(1);
        default: level_d = level_q;
      endcase

      overflow_d  = overflow_q  | (wr_en & full_q);
      underflow_d = underflow_q | (rd_en & empty_q);
    end

    // Status flags are registered from the next level so they track level exactly.
    full_d   = (level_d == DEPTH_L);
    empty_d  = (level_d == {(ADDR_WIDTH+1){1'b0}});
    afull_d  = (level_d >= AF_L);
    aempty_d = (level_d <= AE_L);
  end

  // State registers with asynchronous reset to the empty, error-free state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= {ADDR_WIDTH{1'b0}};
      rd_ptr_q    <= {ADDR_WIDTH{1'b0}};
      level_q     <= {(ADDR_WIDTH+1){1'b0}};
      rd_data_q   <= {DATA_WIDTH{1'b0}};
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
    end
  end

  // Storage array write port; no reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flagged.sv
// Self-checking bench for sync_fifo_flagged: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_sync_fifo_flagged;

  localparam int DW    = 41;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int AET   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          underflow;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ovf;
  logic          m_udf;

  int errors = 0;
  int checks = 0;

  sync_fifo_flagged #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AFT), .AE_THRESH(AET)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, ".rd_data"},      64'(rd_data),      64'(m_data));
    chk({tag, ".rd_valid"},     64'(rd_valid),     64'(m_valid));
    chk({tag, ".level"},        64'(level),        64'(n));
    chk({tag, ".full"},         64'(full),         64'(n == DEPTH));
    chk({tag, ".empty"},        64'(empty),        64'(n == 0));
    chk({tag, ".almost_full"},  64'(almost_full),  64'(n >= AFT));
    chk({tag, ".almost_empty"}, 64'(almost_empty), 64'(n <= AET));
    chk({tag, ".overflow"},     64'(overflow),     64'(m_ovf));
    chk({tag, ".underflow"},    64'(underflow),    64'(m_udf));
  endtask

  task automatic model_reset();
    mq.delete();
    m_data  = '0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_udf   = 1'b0;
  endtask

  // One clock cycle: drive, advance to the edge, update the model from
  // pre-edge state, then check #1 after the edge.
  task automatic step(input logic w, input logic r, input logic fl,
                      input logic [DW-1:0] d, input string tag);
    logic was_full;
    logic was_empty;
    wr_en   = w;
    rd_en   = r;
    flush   = fl;
    wr_data = d;
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (w && was_full)  m_ovf = 1'b1;
      if (r && was_empty) m_udf = 1'b1;
      if (r && !was_empty) begin
        m_data  = mq.pop_front();
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (w && !was_full) mq.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [63:0]   r64;
    logic [DW-1:0] saved;

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0, "idle_after_reset");

    // Fill 16 words, then one extra write that must overflow.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 1'b0, DW'(i), "fill");
    chk("fill_level16", 64'(level), 64'd16);
    step(1'b1, 1'b0, 1'b0, DW'(32'h1FF), "fill_extra");
    chk("extra_overflow", 64'(overflow), 64'd1);
    // Drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 1'b0, '0, "drain");
      chk("drain_order", 64'(rd_data), 64'(i));
    end
    chk("drain_empty", 64'(empty), 64'd1);

    // Flush clears overflow; then read on empty sets underflow; flush clears it.
    step(1'b0, 1'b0, 1'b1, '0, "flush1");
    step(1'b0, 1'b1, 1'b0, '0, "rd_empty");
    chk("rd_empty_udf", 64'(underflow), 64'd1);
    step(1'b0, 1'b0, 1'b1, '0, "flush2");

    // Steady state with wrap: preload 5, then 40 simultaneous cycles.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, DW'(100 + i), "preload");
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 1'b0, DW'(105 + i), "steady");
      chk("steady_level", 64'(level), 64'd5);
      chk("steady_data", 64'(rd_data), 64'(100 + i));
    end

    // Fill to 16, then simultaneous read/write at full.
    for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, DW'(200 + i), "topup");
    step(1'b1, 1'b1, 1'b0, DW'(32'h3AB), "simul_full");
    chk("simul_full_valid", 64'(rd_valid), 64'd1);
    chk("simul_full_level", 64'(level), 64'd15);

    // Set overflow, reduce to 9, then flush with concurrent write.
    step(1'b1, 1'b0, 1'b0, DW'(32'h3AC), "to_full");
    step(1'b1, 1'b0, 1'b0, DW'(32'h3AD), "ovf_again");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, '0, "down_to_9");
    chk("pre_flush_level", 64'(level), 64'd9);
    saved = rd_data;
    step(1'b1, 1'b0, 1'b1, DW'(32'h555), "flush_wr");
    chk("flush_rd_data_hold", 64'(rd_data), 64'(saved));
    step(1'b0, 1'b1, 1'b0, '0, "flush_no_store");
    chk("flush_no_store_udf", 64'(underflow), 64'd1);
    step(1'b0, 1'b0, 1'b1, '0, "flush3");

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      r64 = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 40) == 0), r64[DW-1:0], "random");
    end

    // Asynchronous reset mid-operation, right after a read strobe.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, DW'(300 + i), "pre_areset");
    step(1'b0, 1'b1, 1'b0, '0, "pre_areset_rd");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0, "after_areset");
    step(1'b1, 1'b0, 1'b0, DW'(32'h77), "post_rst_wr");
    step(1'b0, 1'b1, 1'b0, '0, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
